// File: rtl/z80_regload_seq.sv
// Sequenced register-image loader for the T80 DIR/DIRSet port: builds a 212-bit image,
// waits for a safe CPU point, pulses dir_set for SET_CYCLES cycles and reports done.
module z80_regload_seq #(
    parameter logic [15:0] SP_ADDR      = 16'h4200,
    parameter int          SET_CYCLES   = 4,
    parameter int          WAIT_TIMEOUT = 1024
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         img_wr,
    input  logic [4:0]   img_addr,
    input  logic [7:0]   img_data,
    input  logic [15:0]  execute_addr,
    input  logic         execute_enable,
    input  logic [1:0]   execute_method,
    input  logic [211:0] cpu_reg_in,
    input  logic         cpu_safe,
    output logic [211:0] dir_out,
    output logic         dir_set,
    output logic         busy,
    output logic         done,
    output logic         timed_out
);

    // The latch action happens on the edge that leaves WAIT, so no cycle is spent in a
    // separate LATCH state and dir_out is already valid in the first SET cycle.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SET,
        S_DONE
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);
    localparam logic [7:0]  SET_LAST  = 8'(SET_CYCLES - 1);

    state_t         r_state;
    state_t         w_stateNext;
    logic           r_enPrev;
    logic [1:0]     r_method;
    logic [15:0]    r_addr;
    logic [15:0]    r_waitCnt;
    logic [7:0]     r_setCnt;
    logic           r_timedOut;
    logic [211:0]   r_shadow;
    logic [211:0]   r_dirOut;
    logic [211:0]   w_shadowNext;
    logic [211:0]   w_image;
    logic           w_rise;
    logic           w_accept;
    logic           w_latch;
    logic           w_timeout;

    assign w_rise = execute_enable & ~r_enPrev;

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_latch     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_accept    = 1'b1;
                    w_stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cpu_safe) begin
                    w_latch     = 1'b1;
                    w_stateNext = S_SET;
                end else if (r_waitCnt == WAIT_LAST) begin
                    w_latch     = 1'b1;
                    w_timeout   = 1'b1;
                    w_stateNext = S_SET;
                end
            end
            S_SET: begin
                if (r_setCnt == SET_LAST) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Byte 26 only carries the interrupt/IM nibble; indices above 26 fall through untouched.
    always_comb begin
        w_shadowNext = r_shadow;
        if (img_wr && (r_state == S_IDLE)) begin
            for (int k = 0; k < 26; k++) begin
                if (img_addr == 5'(k)) begin
                    w_shadowNext[8*k +: 8] = img_data;
                end
            end
            if (img_addr == 5'd26) begin
                w_shadowNext[211:208] = img_data[3:0];
            end
        end
    end

    always_comb begin
        w_image = cpu_reg_in;
        case (r_method)
            2'b00: begin
                w_image         = '0;
                w_image[79:64]  = r_addr;
                w_image[63:48]  = SP_ADDR;
                w_image[31:0]   = 32'h0101_0001;
            end
            2'b01: begin
                w_image[79:64]  = r_addr;
            end
            2'b10: begin
                w_image         = r_shadow;
            end
            default: begin
                w_image[79:64]  = r_addr;
                w_image[63:48]  = cpu_reg_in[63:48] - 16'd2;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_enPrev   <= 1'b0;
            r_method   <= 2'b00;
            r_addr     <= 16'h0000;
            r_waitCnt  <= 16'h0000;
            r_setCnt   <= 8'h00;
            r_timedOut <= 1'b0;
            r_shadow   <= '0;
            r_dirOut   <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_enPrev <= execute_enable;
            r_shadow <= w_shadowNext;
            if (w_accept) begin
                r_method   <= execute_method;
                r_addr     <= execute_addr;
                r_timedOut <= 1'b0;
                r_waitCnt  <= 16'h0000;
            end else if (r_state == S_WAIT) begin
                r_waitCnt <= r_waitCnt + 16'd1;
            end
            if (w_timeout) begin
                r_timedOut <= 1'b1;
            end
            if (w_latch) begin
                r_dirOut <= w_image;
                r_setCnt <= 8'h00;
            end else if (r_state == S_SET) begin
                r_setCnt <= r_setCnt + 8'd1;
            end
        end
    end

    assign dir_out   = r_dirOut;
    assign dir_set   = (r_state == S_SET);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign timed_out = r_timedOut;

endmodule

// File: doc/z80_regload_seq.md
# z80_regload_seq

Sequenced Z80 register-set loader for the T80/T80pa DIR/DIRSet port. It builds a 212-bit register image from one of four sources, waits for a safe CPU point, and drives dir_set for a programmable number of cycles. It then reports completion. It sits between the program/snapshot loader (which writes image bytes and requests execution) and the CPU core, and supports both "jump to start address" and full snapshot restore.

## Interface
Parameters:
- SP_ADDR, 16'h4200: stack pointer used by method 00.
- SET_CYCLES, 4: number of cycles dir_set is held high (legal range 1–255).
- WAIT_TIMEOUT, 1024: maximum cycles spent in WAIT before the load proceeds anyway (legal range 1–65535).

Ports:
- clk_sys  in  1  system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- img_wr  in  1  write strobe for an image byte.
- img_addr  in  5  image byte index, 0–26.
- img_data  in  8  image byte value.
- execute_addr  in  16  start PC for methods 00, 01 and 11.
- execute_enable  in  1  request; only a rising edge triggers a load.
- execute_method  in  2  00 = fresh, 01 = keep CPU regs, 10 = full image, 11 = keep CPU regs with SP−2.
- cpu_reg_in  in  212  live T80 REG output, in the same layout as dir_out.
- cpu_safe  in  1  high when the CPU may be loaded (e.g. halted or held in wait).
- dir_out  out  212  register image driven to the T80 DIR port.
- dir_set  out  1  T80 DIRSet.
- busy  out  1  high from the accepted request through DONE.
- done  out  1  one-cycle completion pulse.
- timed_out  out  1  sticky; set when WAIT expires, cleared on the next accepted request.

## Operation
- Bit layout (fixed):
  - 211–210: IFF2, IFF1
  - 209–208: IM
  - 207–80: main and alternate registers
  - 79–64: PC
  - 63–48: SP
  - 47–40: R
  - 39–32: I
  - 31–24: Fp
  - 23–16: Ap
  - 15–0: ACC
- Shadow image buffer, 212 bits:
  - Byte k (0–25) maps to bits [8k+7:8k].
  - Byte 26 maps img_data[3:0] to bits 211–208; img_data[7:4] is discarded.
  - img_addr > 26 is ignored.
  - Writes are accepted only while busy=0 and are ignored while busy=1.
  - Reset clears the buffer to zero.
- Image construction happens in LATCH and samples cpu_reg_in on that edge:
  - Method 00:
    - Bits 211–80 are zero.
    - PC = execute_addr.
    - SP = SP_ADDR.
    - R = 0, I = 0.
    - Fp = 8'h01, Ap = 8'h01, ACC = 16'h0001.
  - Method 01: cpu_reg_in with PC replaced by execute_addr.
  - Method 10: the shadow buffer unchanged; PC comes from the image.
  - Method 11: cpu_reg_in with PC = execute_addr and SP = cpu SP − 2, modulo 2^16 (0x0001 → 0xFFFF, 0x0000 → 0xFFFE).
- execute_method and execute_addr are captured at request acceptance, so later changes have no effect on the current load.
- FSM states and transitions:
  - IDLE: a rising edge of execute_enable moves to WAIT. It sets busy and clears timed_out and the wait counter.
  - WAIT: cpu_safe=1 moves to LATCH. If the counter reaches WAIT_TIMEOUT−1 with cpu_safe=0, set timed_out and move to LATCH.
  - LATCH: register dir_out, then move to SET.
  - SET: dir_set=1 for exactly SET_CYCLES cycles, then move to DONE.
  - DONE: done=1 for one cycle, then move to IDLE with busy=0.
- Rising edges of execute_enable while busy=1 are ignored; they are not queued.
- The edge detector keeps its history register updated in every state. A level held high across completion does not retrigger.
- dir_out holds its last value after DONE until the next LATCH.

## Timing
- Reset values: dir_out=0, dir_set=0, busy=0, done=0, timed_out=0, state=IDLE, edge history=0.
- Reset asserted mid-operation returns to IDLE on the next edge and drops dir_set in the same cycle.
- Latency from a request edge at cycle N with cpu_safe already high:
  - busy=1 from N+1.
  - LATCH at N+1 → dir_out valid at N+2.
  - dir_set high for cycles N+2 … N+1+SET_CYCLES.
  - done at N+2+SET_CYCLES.
  - busy=0 at N+3+SET_CYCLES.
- dir_out is stable for every cycle in which dir_set=1.
- A simultaneous img_wr and request edge in IDLE: the write is accepted, and method 10 uses the updated byte.

## Test plan
- Reset, then a method 00 request with execute_addr=16'h5200 and cpu_safe=1 → dir_out[79:64]=5200, [63:48]=4200, [31:0]=32'h0101_0001, rest 0; dir_set high 4 cycles; done 1 cycle later.
- Method 11 with cpu_reg_in SP=16'h0001 and execute_addr=16'h7000 → SP=FFFF and PC=7000; all other bits equal cpu_reg_in.
- Write 27 image bytes (byte k = k, byte 26 = 8'hFA) and issue method 10 → dir_out[207:0] byte k = k, [211:208]=4'hA; a write to img_addr=27 has no effect.
- cpu_safe held 0 with WAIT_TIMEOUT=16 → timed_out=1 after 16 WAIT cycles, the load completes, and timed_out clears on the next request.
- A second request edge and an img_wr during SET → both ignored; dir_out unchanged; exactly one done pulse.
- Reset asserted during SET → dir_set=0, busy=0, dir_out=0 on the next edge; a fresh request afterwards completes normally.
